// File: rtl/ibuf.sv
// ibuf: circular instruction buffer between the IFU and decode, flushed in one cycle on redirect.
// Build option: define IBUF_BYPASS_EN to let an entry pass straight through when the buffer is empty.

package global_config_pkg;
    typedef struct packed {
        int unsigned ILEN;
        int unsigned PLEN;
    } cfg_t;

    localparam cfg_t Cfg = '{ILEN: 32, PLEN: 32};
endpackage

module ibuf #(
    parameter global_config_pkg::cfg_t Cfg = global_config_pkg::Cfg,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned EW = Cfg.ILEN + Cfg.PLEN,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          enq_valid_i,
    output logic          enq_ready_o,
    input  logic [EW-1:0] enq_entry_i,
    output logic          deq_valid_o,
    input  logic          deq_ready_i,
    output logic [EW-1:0] deq_entry_o,
    output logic [CW-1:0] count_o
);

    typedef struct packed {
        logic [Cfg.ILEN-1:0] instr;
        logic [Cfg.PLEN-1:0] pc;
    } ibuf_entry_t;

    ibuf_entry_t   mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;

    logic full;
    logic empty;
    logic pass;
    logic enq_fire;
    logic deq_fire;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    // Ready looks only at registered occupancy and flush, so a full buffer
    // refuses an offer even when decode drains the head in the same cycle.
    assign enq_ready_o = !full && !flush_i;

`ifdef IBUF_BYPASS_EN
    logic bypass;

    assign bypass      = empty && !flush_i;
    assign deq_valid_o = bypass ? enq_valid_i : (!empty && !flush_i);
    assign deq_entry_o = bypass ? enq_entry_i : EW'(mem[head]);
    assign pass        = bypass && enq_valid_i && deq_ready_i;
`else
    assign deq_valid_o = !empty && !flush_i;
    assign deq_entry_o = EW'(mem[head]);
    assign pass        = 1'b0;
`endif

    // A passed-through entry never touches storage, pointers or the counter.
    assign enq_fire = enq_valid_i && enq_ready_o && !pass;
    assign deq_fire = deq_valid_o && deq_ready_i && !pass;
    assign count_o  = cnt;

    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            mem[tail] <= enq_entry_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush_i) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + PW'(1);
            end
            if (deq_fire) begin
                head <= head + PW'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Occupancy must agree with the pointer distance and never exceed capacity.
    a_cnt_range: assert property (@(posedge clk_i) disable iff (rst_i)
        cnt <= CW'(DEPTH));
    a_ptr_dist: assert property (@(posedge clk_i) disable iff (rst_i)
        PW'(tail - head) == PW'(cnt));
    a_flush_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        flush_i |=> (cnt == '0));

endmodule

// File: tb/tb_ibuf.sv
// tb_ibuf: randomized and directed stimulus for ibuf, checked by a queue-based scoreboard.
// Honours IBUF_BYPASS_EN the same way the design does.

module tb_ibuf;
    localparam int DEPTH = 8;
    localparam int EW    = 64;
`ifdef IBUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          enq_valid = 1'b0;
    logic          deq_ready = 1'b0;
    logic [EW-1:0] enq_entry = '0;
    logic          enq_ready;
    logic          deq_valid;
    logic [EW-1:0] deq_entry;
    logic [3:0]    count;

    ibuf #(.DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .enq_valid_i(enq_valid),
        .enq_ready_o(enq_ready),
        .enq_entry_i(enq_entry),
        .deq_valid_o(deq_valid),
        .deq_ready_i(deq_ready),
        .deq_entry_o(deq_entry),
        .count_o    (count)
    );

    always #5 clk = ~clk;

    // Reference model: the ordered list of entries the buffer should hold.
    logic [EW-1:0] q[$];
    bit            pend_push = 1'b0;
    bit            pend_flush = 1'b0;
    logic [EW-1:0] pend_e = '0;
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic [31:0] instr, input logic [31:0] pc);
        return {instr, pc};
    endfunction

    // Monitor: every cycle, check the DUT outputs against the model and
    // retire the head entry whenever decode consumes one.
    always @(negedge clk) begin
        bit empty_byp;
        if (mon_en && !rst) begin
            empty_byp = BYP && (q.size() == 0) && !flush;
            chk("count", 64'(count), 64'(q.size()));
            chk("enq_ready", 64'(enq_ready), 64'(q.size() != DEPTH && !flush));
            chk("deq_valid", 64'(deq_valid),
                64'(empty_byp ? enq_valid : (q.size() != 0 && !flush)));
            if (deq_valid && deq_ready) begin
                if (empty_byp) begin
                    chk("bypass_entry", deq_entry, enq_entry);
                end else if (q.size() != 0) begin
                    chk("deq_entry", deq_entry, q[0]);
                    void'(q.pop_front());
                end
            end
        end
    end

    // One clock of stimulus; the model update it implies is applied at the next edge.
    task automatic cycle(input bit ev, input bit dr, input bit fl,
                         input logic [EW-1:0] e, output bit acc);
        @(posedge clk);
        if (pend_flush) q.delete();
        else if (pend_push) q.push_back(pend_e);
        #1;
        enq_valid = ev;
        deq_ready = dr;
        flush     = fl;
        enq_entry = e;
        pend_flush = fl;
        acc        = !fl && ev && (q.size() != DEPTH);
        pend_push  = acc && !(BYP && q.size() == 0 && dr);
        pend_e     = e;
    endtask

    initial begin
        bit          acc;
        bit          ev;
        bit          dr;
        bit          fl;
        int          dr_pct;
        logic [31:0] pc;
        logic [EW-1:0] e;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_deq_valid", 64'(deq_valid), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        rst = 1'b0;
        mon_en = 1'b1;

        // Fill to capacity, then a ninth offer must be refused
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 1'b0, 1'b0, mk(32'h13 + i, 32'h8000_0000 + 32'(4 * i)), acc);
        cycle(1'b1, 1'b0, 1'b0, mk(32'h99, 32'h8000_0020), acc);
        @(negedge clk);
        chk("full_count", 64'(count), 64'd8);
        chk("full_enq_ready", 64'(enq_ready), 64'd0);

        // Drain in order
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, '0, acc);
        cycle(1'b0, 1'b0, 1'b0, '0, acc);
        @(negedge clk);
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_deq_valid", 64'(deq_valid), 64'd0);

        // Wrap-around streaming at occupancy 3
        pc = 32'h8000_0100;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, mk($urandom, pc), acc);
            pc += 4;
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 1'b0, mk($urandom, pc), acc);
            pc += 4;
        end
        cycle(1'b0, 1'b0, 1'b0, '0, acc);
        @(negedge clk);
        chk("stream_count", 64'(count), 64'd3);

        // Full plus simultaneous dequeue: only the dequeue fires
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 1'b0, mk($urandom, pc), acc);
            pc += 4;
        end
        e = mk(32'h0000_0033, pc);
        cycle(1'b1, 1'b1, 1'b0, e, acc);
        @(negedge clk);
        chk("fulldeq_enq_ready", 64'(enq_ready), 64'd0);
        cycle(1'b1, 1'b0, 1'b0, e, acc);
        @(negedge clk);
        chk("fulldeq_count", 64'(count), 64'd7);
        cycle(1'b0, 1'b0, 1'b0, '0, acc);
        @(negedge clk);
        chk("fulldeq_refill", 64'(count), 64'd8);

        // Flush with concurrent traffic at occupancy 5
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, '0, acc);
        cycle(1'b0, 1'b0, 1'b0, '0, acc);
        @(negedge clk);
        chk("preflush_count", 64'(count), 64'd5);
        cycle(1'b1, 1'b1, 1'b1, mk(32'h77, 32'h8000_0f00), acc);
        @(negedge clk);
        chk("flush_deq_valid", 64'(deq_valid), 64'd0);
        chk("flush_enq_ready", 64'(enq_ready), 64'd0);
        cycle(1'b1, 1'b0, 1'b0, mk(32'h55, 32'h8000_1000), acc);
        @(negedge clk);
        chk("postflush_count", 64'(count), 64'd0);
        chk("postflush_enq_ready", 64'(enq_ready), 64'd1);
        cycle(1'b0, 1'b1, 1'b0, '0, acc);
        @(negedge clk);
        chk("postflush_pc", 64'(deq_entry[31:0]), 64'h8000_1000);
        cycle(1'b0, 1'b0, 1'b0, '0, acc);

        // Empty buffer offer with decode ready: same-cycle only with bypass
        cycle(1'b1, 1'b1, 1'b0, mk(32'h0000_0013, 32'h8000_2000), acc);
        @(negedge clk);
        chk("byp_valid", 64'(deq_valid), 64'(BYP));
        chk("byp_count", 64'(count), 64'd0);
        if (deq_valid) chk("byp_instr", 64'(deq_entry[63:32]), 64'h13);
        cycle(1'b0, 1'b1, 1'b0, '0, acc);
        @(negedge clk);
        chk("byp_next_valid", 64'(deq_valid), 64'(!BYP));
        if (deq_valid) chk("byp_next_instr", 64'(deq_entry[63:32]), 64'h13);
        cycle(1'b0, 1'b0, 1'b0, '0, acc);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0, mk($urandom, pc), acc);
            pc += 4;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_deq_valid", 64'(deq_valid), 64'd0);
        q.delete();
        pend_push  = 1'b0;
        pend_flush = 1'b0;
        enq_valid  = 1'b0;
        deq_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic with varying decode back-pressure
        pc = 32'h9000_0000;
        e  = mk($urandom, pc);
        for (int ph = 0; ph < 6; ph++) begin
            dr_pct = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 85 : 55);
            for (int i = 0; i < 500; i++) begin
                ev = $urandom_range(0, 99) < 75;
                dr = $urandom_range(0, 99) < dr_pct;
                fl = $urandom_range(0, 60) == 0;
                cycle(ev, dr, fl, e, acc);
                if (acc) begin
                    pc += 4;
                    e = mk($urandom, pc);
                end
            end
        end

        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, '0, acc);
        cycle(1'b0, 1'b0, 1'b0, '0, acc);
        @(negedge clk);
        chk("final_count", 64'(count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
